// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_pipe
//   Handshaked execute ALU. Single-cycle ops (AND/OR/ADD/SUB/SLTU/XOR and the
//   unused codes) register their result one cycle after acceptance. MUL is
//   iterative: MUL_STEP multiplier bits are consumed per BUSY cycle, giving a
//   fixed latency of WIDTH/MUL_STEP + 1 cycles. NZCV flags and illegal_op are
//   registered alongside the result and only change when a new result is
//   loaded for presentation.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream presents operands/op
//   in_ready     block can accept (IDLE, or HOLD while out_ready)
//   operand_a    first operand  [WIDTH]
//   operand_b    second operand [WIDTH]
//   alu_control  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLTU, 5 MUL, 6 XOR, others illegal
//   out_valid    result/flags valid (HOLD)
//   out_ready    downstream takes the result
//   result       registered result [WIDTH]
//   flag_n/z/c/v negative, zero, carry, signed overflow
//   illegal_op   the accepted op code was unused; qualified by out_valid
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal_op
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] STEPS_C = CW'(STEPS);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Registered outputs
    logic [WIDTH-1:0] result_reg;
    logic             flag_n_reg, flag_z_reg, flag_c_reg, flag_v_reg;
    logic             illegal_reg;

    // Multiplier state: multiplicand is pre-shifted each step so the partial
    // product can be added without a variable shifter.
    logic [WIDTH-1:0] mul_a_reg;
    logic [WIDTH-1:0] mul_b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;

    // Handshake
    logic accept;
    logic is_mul;
    logic last_step;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_control == OP_MUL);
    assign last_step = (state_reg == BUSY) && (count_reg == ONE_C);

    // -----------------------------------------------------------------------
    // Single-cycle ALU
    // -----------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    // SUB shares the adder as a + ~b + 1, so carry-out means "no borrow".
    assign is_sub = (alu_control == OP_SUB);
    assign b_eff  = is_sub ? ~operand_b : operand_b;
    assign sum    = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Overflow when effective operands agree in sign and the
                // result disagrees; b_eff folds the SUB sign rule in.
                alu_v   = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_MUL:  alu_res = '0;  // handled by the iterative path
            default: alu_ill = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Iterative multiplier step
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;

    assign partial = mul_a_reg * {{(WIDTH-MUL_STEP){1'b0}}, mul_b_reg[MUL_STEP-1:0]};
    assign acc_sum = acc_reg + partial;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : HOLD;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : HOLD;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg  <= '0;
            flag_n_reg  <= 1'b0;
            flag_z_reg  <= 1'b0;
            flag_c_reg  <= 1'b0;
            flag_v_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
        end else if (state_reg == BUSY) begin
            acc_reg   <= acc_sum;
            mul_a_reg <= mul_a_reg << MUL_STEP;
            mul_b_reg <= mul_b_reg >> MUL_STEP;
            count_reg <= count_reg - ONE_C;
            if (last_step) begin
                result_reg  <= acc_sum;
                flag_n_reg  <= acc_sum[WIDTH-1];
                flag_z_reg  <= (acc_sum == '0);
                flag_c_reg  <= 1'b0;
                flag_v_reg  <= 1'b0;
                illegal_reg <= 1'b0;
            end
        end else if (accept) begin
            if (is_mul) begin
                // Result/flags keep their old values until the product lands.
                mul_a_reg <= operand_a;
                mul_b_reg <= operand_b;
                acc_reg   <= '0;
                count_reg <= STEPS_C;
            end else begin
                result_reg  <= alu_res;
                flag_n_reg  <= alu_res[WIDTH-1];
                flag_z_reg  <= (alu_res == '0);
                flag_c_reg  <= alu_c;
                flag_v_reg  <= alu_v;
                illegal_reg <= alu_ill;
            end
        end
    end

    assign result     = result_reg;
    assign flag_n     = flag_n_reg;
    assign flag_z     = flag_z_reg;
    assign flag_c     = flag_c_reg;
    assign flag_v     = flag_v_reg;
    assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_pipe
//   Directed vectors plus randomized traffic against a transaction-level
//   reference: each accepted op is evaluated with plain arithmetic and becomes
//   the single pending result, due a fixed number of cycles after acceptance.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SLTU = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(32), .MUL_STEP(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model state: at most one result outstanding.
    int          cyc = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_res;
    logic [3:0]  pend_flags;
    logic        pend_ill;
    int          pend_ready;
    int          pend_acc;

    // Observed retirement of the most recent step.
    logic        retired, accepted;
    logic [31:0] last_res;
    logic [3:0]  last_flags;
    logic        last_ill;
    int          last_lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural definition of each op; flags packed as {N,Z,C,V}.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f, output logic ill);
        logic [32:0] wide;
        logic [63:0] prod;
        logic c, v;
        c = 1'b0; v = 1'b0; ill = 1'b0; r = 32'h0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_MUL: begin
                prod = {32'h0, a} * {32'h0, b};
                r = prod[31:0];
            end
            default: ill = 1'b1;
        endcase
        f = {r[31], (r == 32'h0), c, v};
    endtask

    // One clock cycle: drive at negedge, check and book-keep once settled.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy);
        logic exp_ov, exp_ir;
        @(negedge clk);
        in_valid = v; alu_control = op; operand_a = a; operand_b = b; out_ready = ordy;
        #1;
        exp_ov = pend && (cyc >= pend_ready);
        exp_ir = !pend || (exp_ov && ordy);
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov) begin
            check_eq("result", result, pend_res);
            check_eq("flags_nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(pend_flags));
            check_eq("illegal_op", 32'(illegal_op), 32'(pend_ill));
        end
        retired  = 1'b0;
        accepted = v && in_ready;
        if (out_valid && out_ready) begin
            retired    = 1'b1;
            last_res   = result;
            last_flags = {flag_n, flag_z, flag_c, flag_v};
            last_ill   = illegal_op;
            last_lat   = cyc - pend_acc;
            $display("[%0t] retire result=%08h nzcv=%b illegal=%0b latency=%0d",
                     $time, result, last_flags, illegal_op, last_lat);
        end
        if (exp_ov && ordy) pend = 1'b0;
        if (v && exp_ir) begin
            ref_alu(op, a, b, pend_res, pend_flags, pend_ill);
            pend       = 1'b1;
            pend_acc   = cyc;
            pend_ready = cyc + ((op == OP_MUL) ? 5 : 1);
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && pend; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        check_eq("drain_done", 32'(pend), 32'd0);
    endtask

    // Issue one op from an empty pipe and wait (bounded) for its result.
    task automatic run_one(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input logic [3:0] exp_f, input logic exp_ill, input int exp_lat);
        logic got;
        drain();
        step(1'b1, op, a, b, 1'b1);
        check_eq({tag, "_accept"}, 32'(accepted), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
            if (retired) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        if (got) begin
            check_eq({tag, "_res"}, last_res, exp_res);
            check_eq({tag, "_nzcv"}, 32'(last_flags), 32'(exp_f));
            check_eq({tag, "_ill"}, 32'(last_ill), 32'(exp_ill));
            check_eq({tag, "_lat"}, 32'(last_lat), 32'(exp_lat));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_control = 4'h0;
        operand_a = 32'h0; operand_b = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        run_one("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110, 1'b0, 1);
        run_one("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, 1'b0, 1);
        run_one("sub_neg", OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1);
        run_one("mul_a", OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 4'b0000, 1'b0, 5);
        run_one("mul_b", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 1'b0, 5);

        // Stall in HOLD for 3 cycles, then 4 back-to-back ADDs
        drain();
        step(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
        repeat (3) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_ADD, 32'(100 * i), 32'h7FFF_FFFF, 1'b1);
            check_eq("b2b_accept", 32'(accepted), 32'd1);
            check_eq("b2b_retire", 32'(retired), 32'd1);
        end
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        check_eq("b2b_last_retire", 32'(retired), 32'd1);

        // Reset during the second BUSY cycle of a MUL
        drain();
        step(1'b1, OP_MUL, 32'd7, 32'd9, 1'b1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midmul_rst_out_valid", 32'(out_valid), 32'd0);
        pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("midmul_in_ready", 32'(in_ready), 32'd1);
        run_one("sltu", OP_SLTU, 32'd3, 32'd5, 32'd1, 4'b0000, 1'b0, 1);

        // Unused op code, then a legal op clears illegal_op
        run_one("illegal", 4'b1111, 32'h1234, 32'h5678, 32'h0, 4'b0100, 1'b1, 1);
        run_one("after_ill", OP_OR, 32'hF0, 32'h0F, 32'hFF, 4'b0000, 1'b0, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] op;
            int r;
            r  = $urandom_range(0, 9);
            op = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
            step(($urandom_range(0, 9) < 7), op, pick_operand(), pick_operand(),
                 ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
